// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - request/result bundle between EX decode and the mul/div unit
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             abort;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, opa, opb, abort,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, opa, opb, abort,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative radix-2 multiply/divide unit owning HI/LO
module ex_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    ex_muldiv_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   raw_a;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               accept;
    logic               accept_md;
    logic               is_signed;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept    = (state == IDLE) && bus.start && !bus.abort;
    assign accept_md = accept && !bus.op[2];

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.done = done_q;
    assign bus.busy = (state != IDLE);

    // Operand conditioning: signed ops work on magnitudes, signs are fixed up at the end
    always_comb begin
        is_signed = !bus.op[0];
        sign_a    = is_signed & bus.opa[WIDTH-1];
        sign_b    = is_signed & bus.opb[WIDTH-1];
        mag_a     = sign_a ? (~bus.opa + 1'b1) : bus.opa;
        mag_b     = sign_b ? (~bus.opb + 1'b1) : bus.opb;
    end

    // One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : {(WIDTH+1){1'b0}});
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, dvs};
        acc_step = '0;
        if (is_div) begin
            if (!rem_diff[WIDTH]) begin
                acc_step = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the finished magnitude result
    always_comb begin
        prod_fix = neg_res ? (~acc + 1'b1) : acc;
        quot_fix = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    // Next-state logic; abort always wins back to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_md) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(WIDTH-1)) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Working registers and HI/LO: load on accept, iterate in CALC, commit in FIX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            dvs      <= '0;
            raw_a    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_md) begin
                        cnt      <= '0;
                        acc      <= {{WIDTH{1'b0}}, mag_a};
                        dvs      <= mag_b;
                        raw_a    <= bus.opa;
                        is_div   <= bus.op[1];
                        neg_res  <= sign_a ^ sign_b;
                        neg_rem  <= sign_a;
                        div_zero <= bus.op[1] && (bus.opb == '0);
                    end else if (accept && bus.op == 3'b100) begin
                        hi_q <= bus.opa;
                    end else if (accept && bus.op == 3'b101) begin
                        lo_q <= bus.opa;
                    end
                end
                CALC: begin
                    if (!bus.abort) begin
                        acc <= acc_step;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (!bus.abort) begin
                        done_q <= 1'b1;
                        if (div_zero) begin
                            lo_q <= '1;
                            hi_q <= raw_a;
                        end else if (is_div) begin
                            lo_q <= quot_fix;
                            hi_q <= rem_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed self-checking bench for ex_muldiv
module tb_ex_muldiv;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    ex_muldiv_if #(.WIDTH(32)) bus ();

    ex_muldiv #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        p = '0;
        case (op)
            3'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
            end
            3'd1: p = {32'b0, a} * {32'b0, b};
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFFFFFF};
                end else if (op == 3'd2) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    p  = {r[31:0], q[31:0]};
                end else begin
                    p = {a % b, a / b};
                end
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Transaction-level reference: an accepted op completes WIDTH+1 edges later
    logic [31:0] m_hi, m_lo;
    logic        m_done;
    int          m_left;
    logic [63:0] m_res;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_left <= 0; m_res <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                if (bus.abort) begin
                    m_left <= 0;
                end else begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_hi   <= m_res[63:32];
                        m_lo   <= m_res[31:0];
                        m_done <= 1'b1;
                    end
                end
            end else if (bus.start && !bus.abort) begin
                if (bus.op <= 3'd3) begin
                    m_res  <= model_fn(bus.op, bus.opa, bus.opb);
                    m_left <= 33;
                end else if (bus.op == 3'd4) begin
                    m_hi <= bus.opa;
                end else if (bus.op == 3'd5) begin
                    m_lo <= bus.opa;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the reference
    always @(negedge clk) begin
        chk("cyc_hi",   bus.hi,   m_hi);
        chk("cyc_lo",   bus.lo,   m_lo);
        chk("cyc_busy", 32'(bus.busy), 32'(m_left != 0));
        chk("cyc_done", 32'(bus.done), 32'(m_done));
    end

    task automatic pulse(input logic [2:0] op_i, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #2;
        bus.start = 1'b1; bus.op = op_i; bus.opa = a; bus.opb = b;
        @(posedge clk); #2;
        bus.start = 1'b0;
    endtask

    // ev_kind: 0 none, 1 stray DIVU start, 2 abort, 3 reset; applied after sample ev_at
    task automatic run_op(input logic [2:0] op_i, input logic [31:0] a, input logic [31:0] b,
                          input int ev_at, input int ev_kind, output int bc, output int dc);
        pulse(op_i, a, b);
        bc = 0;
        dc = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk); #1;
            if (bus.busy) bc++;
            if (bus.done) dc++;
            if (ev_kind != 0 && i == ev_at) begin
                case (ev_kind)
                    1: begin
                        bus.start = 1'b1; bus.op = 3'd3; bus.opa = 32'd100; bus.opb = 32'd7;
                    end
                    2: bus.abort = 1'b1;
                    3: begin
                        reset = 1'b1;
                        #1;
                        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
                        chk("rst_mid_hi", bus.hi, 32'd0);
                        chk("rst_mid_lo", bus.lo, 32'd0);
                    end
                    default: ;
                endcase
            end
            if (ev_kind != 0 && i == ev_at + 1) begin
                bus.start = 1'b0;
                bus.abort = 1'b0;
                reset     = 1'b0;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, dc;
        bus.start = 1'b0; bus.abort = 1'b0; bus.op = 3'd0; bus.opa = '0; bus.opb = '0;
        #1 reset = 1'b1;
        #3;
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, bc, dc);
        chk("multu_hi", bus.hi, 32'hFFFFFFFE);
        chk("multu_lo", bus.lo, 32'h00000001);
        chk("multu_busy_cycles", 32'(bc), 32'd33);
        chk("multu_done_pulses", 32'(dc), 32'd1);

        run_op(3'd0, 32'hFFFFFFFD, 32'd7, 0, 0, bc, dc);
        chk("mult_hi", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo", bus.lo, 32'hFFFFFFEB);

        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 0, bc, dc);
        chk("div_neg_lo", bus.lo, 32'hFFFFFFFD);
        chk("div_neg_hi", bus.hi, 32'hFFFFFFFF);

        run_op(3'd2, 32'd7, 32'hFFFFFFFE, 0, 0, bc, dc);
        chk("div_negb_lo", bus.lo, 32'hFFFFFFFD);
        chk("div_negb_hi", bus.hi, 32'd1);

        run_op(3'd3, 32'd100, 32'd7, 0, 0, bc, dc);
        chk("divu_lo", bus.lo, 32'd14);
        chk("divu_hi", bus.hi, 32'd2);

        run_op(3'd3, 32'h12345678, 32'd0, 0, 0, bc, dc);
        chk("divz_lo", bus.lo, 32'hFFFFFFFF);
        chk("divz_hi", bus.hi, 32'h12345678);
        chk("divz_busy_cycles", 32'(bc), 32'd33);

        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, bc, dc);
        chk("div_ovf_lo", bus.lo, 32'h80000000);
        chk("div_ovf_hi", bus.hi, 32'd0);

        // MTHI then MTLO on back-to-back edges
        @(posedge clk); #2;
        bus.start = 1'b1; bus.op = 3'd4; bus.opa = 32'hAAAA5555;
        @(posedge clk); #1;
        chk("mthi_hi", bus.hi, 32'hAAAA5555);
        chk("mthi_busy", 32'(bus.busy), 32'd0);
        #1;
        bus.op = 3'd5; bus.opa = 32'h0F0F0F0F;
        @(posedge clk); #1;
        chk("mtlo_lo", bus.lo, 32'h0F0F0F0F);
        chk("mtlo_hi_kept", bus.hi, 32'hAAAA5555);
        chk("mtlo_busy", 32'(bus.busy), 32'd0);
        chk("mtlo_done", 32'(bus.done), 32'd0);
        #1 bus.start = 1'b0;

        run_op(3'd1, 32'd5, 32'd6, 9, 1, bc, dc);
        chk("stray_hi", bus.hi, 32'd0);
        chk("stray_lo", bus.lo, 32'd30);
        chk("stray_done_pulses", 32'(dc), 32'd1);

        pulse(3'd4, 32'd1, 32'd0);
        pulse(3'd5, 32'd2, 32'd0);
        run_op(3'd2, 32'd100, 32'd7, 14, 2, bc, dc);
        chk("abort_hi", bus.hi, 32'd1);
        chk("abort_lo", bus.lo, 32'd2);
        chk("abort_done_pulses", 32'(dc), 32'd0);
        chk("abort_busy_cycles", 32'(bc), 32'd15);

        pulse(3'd4, 32'd1, 32'd0);
        pulse(3'd5, 32'd2, 32'd0);
        run_op(3'd2, 32'd100, 32'd7, 14, 3, bc, dc);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        chk("reset_done_pulses", 32'(dc), 32'd0);

        repeat (2) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
